// File: rtl/toggle_event_decoder.sv
// Toggle-to-pulse event decoder.
// Synchronises a toggle line, emits a pulse per edge, counts events.
module toggle_event_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tog_in,
  input  logic                 en,
  input  logic                 clr,
  output logic                 armed,
  output logic                 level,
  output logic                 pulse,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow
);

  localparam int PW = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] sync;
  logic [PW-1:0]          prime;
  logic                   s_last;
  logic                   toggle;
  logic                   event_ok;
  logic                   wrap;

  assign s_last   = sync[SYNC_STAGES-1];
  assign toggle   = s_last ^ level;
  assign event_ok = armed & en & toggle;
  assign wrap     = (count == {CNT_WIDTH{1'b1}});

  // Synchroniser chain and previous-level register, always tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      level <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], tog_in};
      level <= s_last;
    end
  end

  // Priming: arm once chain and level hold post-reset data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime <= '0;
      armed <= 1'b0;
    end else if (!armed) begin
      prime <= prime + PW'(1);
      if (prime == PW'(SYNC_STAGES))
        armed <= 1'b1;
    end
  end

  // Registered event pulse, suppressed until armed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pulse <= 1'b0;
    else
      pulse <= event_ok;
  end

  // Wrapping event counter with sticky overflow; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (event_ok) begin
      count <= count + CNT_WIDTH'(1);
      if (wrap)
        overflow <= 1'b1;
    end
  end

endmodule

// File: doc/toggle_event_decoder.md
Name: toggle_event_decoder

Overview:
Receive-side counterpart of the T flip-flop toggle scheme. The upstream transmitter encodes each event as a toggle of a level signal. This block synchronises that level, turns every toggle (either edge) back into a one-cycle event pulse, and keeps a wrapping event count with a sticky overflow flag. It sits in front of any logic that consumes events carried as a toggling line.

Parameters:
SYNC_STAGES, 2, depth of the input synchroniser chain; legal values are 2 or more.
CNT_WIDTH, 8, width of the event counter.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
tog_in  input  1  toggle-encoded event level from the transmitter.
en  input  1  decode enable; when 0, no pulses are emitted and no events are counted.
clr  input  1  synchronous clear of count and overflow.
armed  output  1  high once the synchroniser holds valid post-reset data.
level  output  1  synchronised and registered tog_in level (prev register).
pulse  output  1  one-cycle pulse per detected toggle.
count  output  CNT_WIDTH  number of events counted, wrapping.
overflow  output  1  sticky; set when count wraps from all-ones to 0.

Behaviour:
- Reset (rst_n=0, asynchronous): sync chain, level, pulse, count, overflow, armed and the prime counter all clear to 0 immediately.
- Sync chain:
  - s[0] <= tog_in; s[i] <= s[i-1].
  - s_last = s[SYNC_STAGES-1].
  - level <= s_last on every edge, regardless of en.
- Priming:
  - Edges 1..SYNC_STAGES+1 after rst_n deasserts: level loads s_last; pulse is forced to 0.
  - armed sets on edge SYNC_STAGES+1 and stays 1 until the next reset.
  - A tog_in held at 1 through reset release therefore produces no pulse.
- Detection, when armed=1:
  - toggle = s_last ^ level.
  - pulse <= en & toggle (registered output).
- Latency: a tog_in change sampled at edge k gives pulse=1 from edge k+SYNC_STAGES until edge k+SYNC_STAGES+1.
- Back-to-back toggles: tog_in changes on consecutive cycles give pulses on consecutive cycles, one per change. No events are merged or lost while each level is held at least 1 cycle.
- Count:
  - On a cycle where en & toggle & armed, count <= count+1 (mod 2^CNT_WIDTH).
  - An increment from all-ones wraps to 0 and sets overflow=1.
  - overflow clears only on clr or reset.
- en=0:
  - Sync chain and level keep tracking, so re-enabling with no new toggle produces no pulse.
  - Toggles seen while disabled are discarded and never counted later.
- clr=1:
  - count <= 0 and overflow <= 0, with priority over a coincident increment; that event is not counted.
  - pulse for a coincident event is still asserted.
- Reset mid-operation: all state is lost. Priming restarts, and no pulse is generated for the level present at release.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- SYNC_STAGES=2, CNT_WIDTH=4, tog_in=0, release rst_n -> armed=1 after edge 3; pulse=0, count=0, overflow=0, level=0.
- tog_in held 1 through reset release -> armed at edge 3, level=1, pulse stays 0, count=0.
- After armed, tog_in 0->1 sampled at edge k -> pulse=1 only in the cycle after edge k+2; count=1. Then 1->0 -> second pulse; count=2.
- 16 toggles spaced 2 cycles apart -> 16 pulses; count reads 15, then wraps to 0 on the 16th; overflow=1 and stays 1. Then clr -> count=0, overflow=0.
- tog_in pattern 0,1,0,1 on consecutive cycles -> 3 pulses on consecutive cycles; count=3.
- en=0 during 3 toggles -> pulse=0, count unchanged; re-enable with no change -> no pulse. clr on the same edge as a detected toggle -> pulse=1, count=0. rst_n low mid-burst -> all outputs 0 immediately, re-prime exactly as in the first scenario.
